// File: rtl/voice_allocator.sv
// voice_allocator
// Schedules note-on / note-off events onto a small pool of wave-generator
// voices. Each voice is IDLE, HELD (gate high) or RELEASE (gate low, release
// tail still sounding). New notes retrigger a voice already holding the same
// note, else take the lowest IDLE voice, else the oldest RELEASE voice, else
// steal the oldest HELD voice.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   note_on       one-cycle request to start note_on_num (note 0 is a rest, ignored)
//   note_on_num   note for note_on
//   note_off      one-cycle request to release note_off_num
//   note_off_num  note for note_off
//   all_off       releases every HELD voice
//   voice_note    per-voice note, voice i at [i*NOTE_WIDTH +: NOTE_WIDTH]
//   voice_gate    high while a voice is HELD
//   voice_trig    one-cycle pulse when a voice is (re)assigned
//   stolen        one-cycle pulse when an allocation takes a HELD voice
//   active_count  number of voices not IDLE
module voice_allocator #(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_WIDTH = 6,
    parameter int REL_CYCLES = 4800,
    parameter int REL_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             note_on,
    input  logic [NOTE_WIDTH-1:0]            note_on_num,
    input  logic                             note_off,
    input  logic [NOTE_WIDTH-1:0]            note_off_num,
    input  logic                             all_off,
    output logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note,
    output logic [NUM_VOICES-1:0]            voice_gate,
    output logic [NUM_VOICES-1:0]            voice_trig,
    output logic                             stolen,
    output logic [3:0]                       active_count
);

    localparam int RANK_WIDTH = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {
        V_IDLE    = 2'd0,
        V_HELD    = 2'd1,
        V_RELEASE = 2'd2
    } voice_state_t;

    // Registered per-voice state
    voice_state_t          state_q [NUM_VOICES];
    logic [NOTE_WIDTH-1:0] note_q  [NUM_VOICES];
    logic [REL_WIDTH-1:0]  cnt_q   [NUM_VOICES];
    logic [RANK_WIDTH-1:0] rank_q  [NUM_VOICES];

    // Next-state values
    voice_state_t          state_d [NUM_VOICES];
    logic [NOTE_WIDTH-1:0] note_d  [NUM_VOICES];
    logic [REL_WIDTH-1:0]  cnt_d   [NUM_VOICES];
    logic [RANK_WIDTH-1:0] rank_d  [NUM_VOICES];

    // State after note_off / all_off only; allocation is judged against this
    voice_state_t          rel_state [NUM_VOICES];
    logic [NUM_VOICES-1:0] newly_released;

    // Candidate selection
    logic                  hit_found, idle_found, rel_found, old_found;
    logic [RANK_WIDTH-1:0] hit_idx, idle_idx, rel_idx, old_idx;
    logic [RANK_WIDTH-1:0] rel_rank, old_rank;
    logic                  alloc;
    logic                  steal;
    logic [RANK_WIDTH-1:0] sel_idx;
    logic [RANK_WIDTH-1:0] sel_rank;

    // Next output values
    logic [NUM_VOICES-1:0] gate_d;
    logic [NUM_VOICES-1:0] trig_d;
    logic [3:0]            count_d;

    // Release stage: off events act before any note_on in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            newly_released[i] = 1'b0;
            rel_state[i]      = state_q[i];
            if (state_q[i] == V_HELD &&
                (all_off || (note_off && note_q[i] == note_off_num))) begin
                rel_state[i]      = V_RELEASE;
                newly_released[i] = 1'b1;
            end
        end
    end

    // Candidate search. Higher rank means older; ranks form a permutation,
    // so the oldest RELEASE/HELD candidate is unique.
    always_comb begin
        hit_found  = 1'b0;
        hit_idx    = '0;
        idle_found = 1'b0;
        idle_idx   = '0;
        rel_found  = 1'b0;
        rel_idx    = '0;
        rel_rank   = '0;
        old_found  = 1'b0;
        old_idx    = '0;
        old_rank   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!hit_found && rel_state[i] == V_HELD && note_q[i] == note_on_num) begin
                hit_found = 1'b1;
                hit_idx   = RANK_WIDTH'(i);
            end
            if (!idle_found && rel_state[i] == V_IDLE) begin
                idle_found = 1'b1;
                idle_idx   = RANK_WIDTH'(i);
            end
            if (rel_state[i] == V_RELEASE && (!rel_found || rank_q[i] > rel_rank)) begin
                rel_found = 1'b1;
                rel_idx   = RANK_WIDTH'(i);
                rel_rank  = rank_q[i];
            end
            if (rel_state[i] == V_HELD && (!old_found || rank_q[i] > old_rank)) begin
                old_found = 1'b1;
                old_idx   = RANK_WIDTH'(i);
                old_rank  = rank_q[i];
            end
        end
    end

    // Allocation priority: retrigger, idle, oldest release, steal oldest held.
    always_comb begin
        alloc   = note_on && (note_on_num != '0);
        steal   = 1'b0;
        sel_idx = '0;
        if (hit_found) begin
            sel_idx = hit_idx;
        end else if (idle_found) begin
            sel_idx = idle_idx;
        end else if (rel_found) begin
            sel_idx = rel_idx;
        end else begin
            sel_idx = old_idx;
            steal   = alloc && old_found;
        end
        sel_rank = rank_q[sel_idx];
    end

    // Next-state logic for every voice: release timing first, then the
    // allocation overrides the chosen voice and ages the younger ones.
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            state_d[i] = rel_state[i];
            note_d[i]  = note_q[i];
            cnt_d[i]   = cnt_q[i];
            rank_d[i]  = rank_q[i];
            trig_d[i]  = 1'b0;
            if (newly_released[i]) begin
                cnt_d[i] = REL_WIDTH'(REL_CYCLES - 1);
            end else if (state_q[i] == V_RELEASE) begin
                if (cnt_q[i] == '0) begin
                    state_d[i] = V_IDLE;
                end else begin
                    cnt_d[i] = cnt_q[i] - REL_WIDTH'(1);
                end
            end
            if (alloc && sel_idx == RANK_WIDTH'(i)) begin
                state_d[i] = V_HELD;
                note_d[i]  = note_on_num;
                cnt_d[i]   = '0;
                rank_d[i]  = '0;
                trig_d[i]  = 1'b1;
            end else if (alloc && rank_q[i] < sel_rank) begin
                rank_d[i] = rank_q[i] + RANK_WIDTH'(1);
            end
        end
    end

    // Output values derived from the next state so they line up with it.
    always_comb begin
        gate_d  = '0;
        count_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            gate_d[i] = (state_d[i] == V_HELD);
            if (state_d[i] != V_IDLE) begin
                count_d = count_d + 4'd1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                state_q[i] <= V_IDLE;
                note_q[i]  <= '0;
                cnt_q[i]   <= '0;
                rank_q[i]  <= RANK_WIDTH'(i);
            end
            voice_gate   <= '0;
            voice_trig   <= '0;
            stolen       <= 1'b0;
            active_count <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                state_q[i] <= state_d[i];
                note_q[i]  <= note_d[i];
                cnt_q[i]   <= cnt_d[i];
                rank_q[i]  <= rank_d[i];
            end
            voice_gate   <= gate_d;
            voice_trig   <= trig_d;
            stolen       <= steal;
            active_count <= count_d;
        end
    end

    // Notes are driven straight from their registers.
    always_comb begin
        voice_note = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note[i*NOTE_WIDTH +: NOTE_WIDTH] = note_q[i];
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator
// Directed scenarios followed by random note traffic. The reference model
// tracks each voice as held / released-at-edge, keeps ages as an ordered
// list (newest first), and derives IDLE from elapsed release time.
module tb_voice_allocator;

    localparam int NV = 3;
    localparam int NW = 6;
    localparam int RC = 8;
    localparam int RW = 16;

    localparam int ST_IDLE = 0;
    localparam int ST_REL  = 1;
    localparam int ST_HELD = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             note_on = 1'b0;
    logic [NW-1:0]    note_on_num = '0;
    logic             note_off = 1'b0;
    logic [NW-1:0]    note_off_num = '0;
    logic             all_off = 1'b0;
    logic [NV*NW-1:0] voice_note;
    logic [NV-1:0]    voice_gate;
    logic [NV-1:0]    voice_trig;
    logic             stolen;
    logic [3:0]       active_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_note [NV];
    bit          m_held [NV];
    bit          m_rel  [NV];
    int          m_rel_edge [NV];
    int          age_q [$];
    int          now;
    bit [NV-1:0] e_trig;
    bit          e_stolen;

    voice_allocator #(
        .NUM_VOICES(NV),
        .NOTE_WIDTH(NW),
        .REL_CYCLES(RC),
        .REL_WIDTH (RW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .note_on     (note_on),
        .note_on_num (note_on_num),
        .note_off    (note_off),
        .note_off_num(note_off_num),
        .all_off     (all_off),
        .voice_note  (voice_note),
        .voice_gate  (voice_gate),
        .voice_trig  (voice_trig),
        .stolen      (stolen),
        .active_count(active_count)
    );

    always #5 clk = ~clk;

    // A released voice falls silent RC edges after the edge that released it.
    function automatic int effState(int v);
        if (m_held[v]) return ST_HELD;
        if (m_rel[v] && (now - m_rel_edge[v]) < RC) return ST_REL;
        return ST_IDLE;
    endfunction

    function automatic void modelReset();
        age_q.delete();
        for (int v = 0; v < NV; v++) begin
            m_note[v]     = 0;
            m_held[v]     = 1'b0;
            m_rel[v]      = 1'b0;
            m_rel_edge[v] = 0;
            age_q.push_back(v);
        end
        now      = 0;
        e_trig   = '0;
        e_stolen = 1'b0;
    endfunction

    function automatic void modelStep(bit on, int onn, bit off, int offn, bit ao);
        int st [NV];
        int pick;
        int edge_n;
        edge_n   = now + 1;
        e_trig   = '0;
        e_stolen = 1'b0;
        for (int v = 0; v < NV; v++) st[v] = effState(v);
        for (int v = 0; v < NV; v++) begin
            if (st[v] == ST_HELD && (ao || (off && m_note[v] == offn))) begin
                m_held[v]     = 1'b0;
                m_rel[v]      = 1'b1;
                m_rel_edge[v] = edge_n;
                st[v]         = ST_REL;
            end
        end
        if (on && onn != 0) begin
            pick = -1;
            for (int v = 0; v < NV; v++)
                if (pick < 0 && st[v] == ST_HELD && m_note[v] == onn) pick = v;
            for (int v = 0; v < NV; v++)
                if (pick < 0 && st[v] == ST_IDLE) pick = v;
            for (int k = age_q.size() - 1; k >= 0; k--)
                if (pick < 0 && st[age_q[k]] == ST_REL) pick = age_q[k];
            if (pick < 0) begin
                pick     = age_q[age_q.size() - 1];
                e_stolen = 1'b1;
            end
            m_held[pick] = 1'b1;
            m_rel[pick]  = 1'b0;
            m_note[pick] = onn;
            e_trig[pick] = 1'b1;
            for (int k = 0; k < age_q.size(); k++) begin
                if (age_q[k] == pick) begin
                    age_q.delete(k);
                    break;
                end
            end
            age_q.push_front(pick);
        end
        now = edge_n;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [NV*NW-1:0] en;
        logic [NV-1:0]    eg;
        int               ac;
        ac = 0;
        for (int v = 0; v < NV; v++) begin
            en[v*NW +: NW] = NW'(m_note[v]);
            eg[v]          = m_held[v];
            if (effState(v) != ST_IDLE) ac++;
        end
        checkVal({tag, ".note"},   32'(voice_note),   32'(en));
        checkVal({tag, ".gate"},   32'(voice_gate),   32'(eg));
        checkVal({tag, ".trig"},   32'(voice_trig),   32'(e_trig));
        checkVal({tag, ".stolen"}, 32'(stolen),       32'(e_stolen));
        checkVal({tag, ".active"}, 32'(active_count), 32'(ac));
    endtask

    // One clock of stimulus: drive, clock, advance the model, then check.
    task automatic applyStimulus(input bit on, input int onn, input bit off, input int offn,
                                 input bit ao, input string tag);
        note_on      = on;
        note_on_num  = NW'(onn);
        note_off     = off;
        note_off_num = NW'(offn);
        all_off      = ao;
        @(posedge clk);
        modelStep(on, onn & 63, off, offn & 63, ao);
        #1;
        note_on  = 1'b0;
        note_off = 1'b0;
        all_off  = 1'b0;
        checkOutput(tag);
    endtask

    task automatic doReset(input string tag);
        note_on  = 1'b0;
        note_off = 1'b0;
        all_off  = 1'b0;
        reset_n  = 1'b0;
        #2;
        modelReset();
        checkOutput(tag);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, tag);
    endtask

    initial begin
        bit on, off, ao;
        int onn, offn;
        #1;
        $display("[TB] voice_allocator bench starting");

        // Reset state and a single allocation
        doReset("rst0");
        checkVal("rst0.gate_zero", 32'(voice_gate), 32'd0);
        applyStimulus(1'b1, 12, 1'b0, 0, 1'b0, "on12");
        checkVal("on12.trig",   32'(voice_trig),   32'b001);
        checkVal("on12.gate",   32'(voice_gate),   32'b001);
        checkVal("on12.note0",  32'(voice_note[5:0]), 32'd12);
        checkVal("on12.active", 32'(active_count), 32'd1);

        // Full pool then steal the oldest
        doReset("rst1");
        applyStimulus(1'b1, 12, 1'b0, 0, 1'b0, "fill12");
        applyStimulus(1'b1, 14, 1'b0, 0, 1'b0, "fill14");
        applyStimulus(1'b1, 16, 1'b0, 0, 1'b0, "fill16");
        applyStimulus(1'b1, 19, 1'b0, 0, 1'b0, "steal19");
        checkVal("steal19.stolen", 32'(stolen),     32'd1);
        checkVal("steal19.trig",   32'(voice_trig), 32'b001);
        checkVal("steal19.gate",   32'(voice_gate), 32'b111);
        checkVal("steal19.notes",  32'(voice_note), 32'({6'd16, 6'd14, 6'd19}));

        // Release timing: active for RC cycles after the gate falls
        doReset("rst2");
        applyStimulus(1'b1, 12, 1'b0, 0, 1'b0, "rel.on");
        applyStimulus(1'b0, 0, 1'b1, 12, 1'b0, "rel.off");
        checkVal("rel.off.gate",   32'(voice_gate),   32'd0);
        checkVal("rel.off.active", 32'(active_count), 32'd1);
        for (int k = 1; k < RC; k++) begin
            applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, "rel.wait");
            checkVal("rel.wait.active", 32'(active_count), 32'd1);
        end
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, "rel.done");
        checkVal("rel.done.active", 32'(active_count), 32'd0);

        // RELEASE voice preferred over stealing
        doReset("rst3");
        applyStimulus(1'b1, 12, 1'b0, 0, 1'b0, "reuse12");
        applyStimulus(1'b1, 14, 1'b0, 0, 1'b0, "reuse14");
        applyStimulus(1'b1, 16, 1'b0, 0, 1'b0, "reuse16");
        applyStimulus(1'b0, 0, 1'b1, 14, 1'b0, "reuse.off14");
        applyStimulus(1'b1, 20, 1'b0, 0, 1'b0, "reuse.on20");
        checkVal("reuse.stolen", 32'(stolen),     32'd0);
        checkVal("reuse.trig",   32'(voice_trig), 32'b010);
        checkVal("reuse.note1",  32'(voice_note[11:6]), 32'd20);

        // Retrigger of a held note, then a steal revealing the new ages
        doReset("rst4");
        applyStimulus(1'b1, 12, 1'b0, 0, 1'b0, "rt12");
        applyStimulus(1'b1, 14, 1'b0, 0, 1'b0, "rt14");
        applyStimulus(1'b1, 16, 1'b0, 0, 1'b0, "rt16");
        applyStimulus(1'b1, 12, 1'b0, 0, 1'b0, "rt.again12");
        checkVal("rt.trig",   32'(voice_trig), 32'b001);
        checkVal("rt.notes",  32'(voice_note), 32'({6'd16, 6'd14, 6'd12}));
        checkVal("rt.stolen", 32'(stolen),     32'd0);
        applyStimulus(1'b1, 30, 1'b0, 0, 1'b0, "rt.steal30");
        checkVal("rt.steal.trig", 32'(voice_trig), 32'b010);

        // Same-cycle off/on of one note, then all_off
        doReset("rst5");
        applyStimulus(1'b1, 12, 1'b0, 0, 1'b0, "same12");
        applyStimulus(1'b1, 14, 1'b0, 0, 1'b0, "same14");
        applyStimulus(1'b1, 16, 1'b0, 0, 1'b0, "same16");
        applyStimulus(1'b1, 14, 1'b1, 14, 1'b0, "same.offon14");
        checkVal("same.gate", 32'(voice_gate), 32'b111);
        checkVal("same.trig", 32'(voice_trig), 32'b010);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, "alloff");
        checkVal("alloff.gate", 32'(voice_gate), 32'b000);
        applyStimulus(1'b1, 22, 1'b0, 0, 1'b1, "alloff.on22");
        idle(3, "alloff.tail");

        // Reset in the middle of a release, checked before the next edge
        doReset("rst6");
        applyStimulus(1'b1, 12, 1'b0, 0, 1'b0, "mid.on");
        applyStimulus(1'b0, 0, 1'b1, 12, 1'b0, "mid.off");
        idle(2, "mid.wait");
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("mid.rst");
        checkVal("mid.rst.active", 32'(active_count), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, "mid.after");
            checkVal("mid.after.trig", 32'(voice_trig), 32'd0);
        end

        // Random traffic over a small note set to force collisions
        doReset("rst7");
        for (int k = 0; k < 1500; k++) begin
            on   = ($urandom_range(0, 2) == 0);
            onn  = $urandom_range(0, 7);
            off  = ($urandom_range(0, 2) == 0);
            offn = $urandom_range(0, 7);
            ao   = ($urandom_range(0, 39) == 0);
            applyStimulus(on, onn, off, offn, ao, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Schedules keypad/sequencer note events onto the shared pool of wave-generator voices (wave1..wave3) feeding the mixer, ADSR and echo chain.
- Per voice it holds the assigned note, drives a gate and a one-cycle trigger, and tracks release time.
- When no voice is free it steals according to a fixed priority and age order.
- Sits between the note-event source (keypad decoder / music_player note stream) and the per-voice note/gate inputs of the wave generators.

Parameters:
- NUM_VOICES, 3: number of voices sharing the pool (2..8).
- NOTE_WIDTH, 6: note index width; note 0 is reserved as a rest.
- REL_CYCLES, 4800: cycles a voice stays in RELEASE after its gate falls.
- REL_WIDTH, 16: width of the per-voice release counter; must satisfy REL_CYCLES < 2^REL_WIDTH.

Ports:
- clk, in, 1: system clock (100 MHz).
- reset_n, in, 1: asynchronous, active-low reset.
- note_on, in, 1: one-cycle pulse requesting that note_on_num be started.
- note_on_num, in, NOTE_WIDTH: note for note_on.
- note_off, in, 1: one-cycle pulse requesting release of note_off_num.
- note_off_num, in, NOTE_WIDTH: note for note_off.
- all_off, in, 1: pulse; every HELD voice goes to RELEASE.
- voice_note, out, NUM_VOICES*NOTE_WIDTH: per-voice note, voice i in bits [i*NOTE_WIDTH +: NOTE_WIDTH].
- voice_gate, out, NUM_VOICES: high while the voice is HELD.
- voice_trig, out, NUM_VOICES: one-cycle pulse when a voice is (re)assigned.
- stolen, out, 1: one-cycle pulse when an allocation steals a HELD voice.
- active_count, out, 4: number of voices not IDLE.

Behaviour:
Reset (reset_n low, asynchronous):
- All voices go to IDLE with note 0.
- All gate, trig, stolen and active_count outputs are 0.
- Age ranks are set to rank[i] = i.

Per-voice FSM:
- IDLE -> HELD on allocation.
- HELD -> RELEASE on a matching note_off or on all_off; the release counter loads REL_CYCLES-1.
- RELEASE decrements its counter each cycle and goes to IDLE when the counter is 0.
- RELEASE -> HELD on allocation.
- HELD -> HELD on retrigger or steal.

Ages:
- rank is a permutation of 0..NUM_VOICES-1; 0 is the newest.
- On allocating voice v with rank r: every voice with rank < r increments, and v gets rank 0.
- Ranks change only on allocation.

note_on handling (note_on_num != 0; a note_on with note 0 is ignored entirely):
1. If some HELD voice already has note_on_num, retrigger that voice: trig pulses, note is unchanged, rank is updated.
2. Otherwise use the lowest-index IDLE voice.
3. Otherwise use the RELEASE voice with the highest rank.
4. Otherwise steal the HELD voice with the highest rank and pulse stolen.
- The chosen voice loads note_on_num, raises its gate and pulses its trig.

note_off handling:
- Releases every HELD voice whose note equals note_off_num.
- If no voice matches, there is no effect.
- A note_off for a voice already in RELEASE is ignored.

Timing:
- All outputs are registered.
- Input pulse in cycle t produces visible output in cycle t+1.
- voice_trig and stolen are high for exactly one cycle.

Simultaneous events, in the same cycle:
- all_off and note_off are applied first, then note_on is evaluated against the post-release state.
- A note_on and note_off for the same note in the same cycle leave the voice HELD with trig=1.
- all_off together with note_on leaves only the newly allocated voice HELD.

Retrigger of a RELEASE voice:
- Reachable only via step 3; the release counter is cleared on entry to HELD.

active_count:
- Combinational count of non-IDLE voices, registered; it equals the FSM state at t+1.

Reset mid-operation:
- Gates and trigs drop immediately and asynchronously; no trig pulse is generated on reset release.

Width rules:
- The release counter saturates at 0.
- rank width is clog2(NUM_VOICES), with a minimum of 1.

Test Plan:
- Reset, then note_on 12 -> at t+1 voice_trig=001, voice_gate=001, voice0 note=12, active_count=1.
- note_on 12, 14, 16 in successive cycles, then note_on 19 -> voice0 (oldest, note 12) loads 19, stolen=1, trig=001, gate=111.
- note_on 12, then note_off 12 -> gate=000 and active_count stays 1 for REL_CYCLES cycles, then 0 (bench uses REL_CYCLES=8: IDLE exactly 8 cycles after the gate falls).
- Voices 0/1/2 HELD with 12/14/16; note_off 14; note_on 20 -> voice1 reused (RELEASE preferred over stealing), stolen=0, voice1 note=20.
- note_on 12 while 12 is HELD in voice0 -> trig=001, note unchanged, no other voice changes, ranks updated.
- Same-cycle note_off 14 and note_on 14 with 14 HELD in voice1 -> gate[1] stays 1 and trig=010. all_off with 3 HELD -> gate=000.
- Pulling reset_n low mid-release -> all outputs 0 within the same cycle, with no trig on reset release.
